// File: rtl/vl6180x_i2c_target.sv
// rtl/vl6180x_i2c_target.sv - VL6180X register-emulating I2C target at DEV_ADDR with range measurement model
// Define VL6180X_GPIO1_INT_EN to drive gpio1_n from INT_STATUS; otherwise gpio1_n is tied high.
module vl6180x_i2c_target #(
    parameter logic [6:0]  DEV_ADDR    = 7'h29,
    parameter logic [7:0]  MODEL_ID    = 8'hB4,
    parameter logic [23:0] MEAS_CYCLES = 24'd12000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    input  logic [7:0] range_mm,
    output logic       meas_busy,
    output logic       gpio1_n
);
    typedef enum logic [3:0] {
        IDLE, ADDR, ACK_ADDR, IDX_HI, ACK_HI, IDX_LO, ACK_LO,
        WDATA, ACK_W, RDATA, RACK, IGNORE
    } state_t;

    // [0],[1] synchronizer stages, [2] history for edge detection
    logic [2:0]  scl_pipe_q, scl_pipe_d;
    logic [2:0]  sda_pipe_q, sda_pipe_d;
    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [3:0]  idx_hi_q, idx_hi_d;
    logic [11:0] ptr_q, ptr_d;
    logic        rack_q, rack_d;
    logic        sda_oe_q, sda_oe_d;
    logic        fresh_q, fresh_d;
    logic [2:0]  int_st_q, int_st_d;
    logic [7:0]  range_val_q, range_val_d;
    logic        busy_q, busy_d;
    logic [23:0] meas_cnt_q, meas_cnt_d;

    logic scl_s, scl_h, sda_s, sda_h;
    logic scl_rise, scl_fall, start_ev, stop_ev;
    logic wr_en;
    logic [7:0] rd_byte;

    assign scl_s    = scl_pipe_q[1];
    assign scl_h    = scl_pipe_q[2];
    assign sda_s    = sda_pipe_q[1];
    assign sda_h    = sda_pipe_q[2];
    assign scl_rise = scl_s & ~scl_h;
    assign scl_fall = ~scl_s & scl_h;
    assign start_ev = scl_s & scl_h & ~sda_s & sda_h;
    assign stop_ev  = scl_s & scl_h & sda_s & ~sda_h;

    assign sda_oe    = sda_oe_q;
    assign meas_busy = busy_q;

    always_comb begin
        rd_byte = 8'h00;
        case (ptr_q)
            12'h000: rd_byte = MODEL_ID;
            12'h016: rd_byte = {7'd0, fresh_q};
            12'h04F: rd_byte = {5'd0, int_st_q};
            12'h062: rd_byte = range_val_q;
            default: rd_byte = 8'h00;
        endcase
    end

    always_comb begin
        scl_pipe_d = {scl_pipe_q[1:0], scl_i};
        sda_pipe_d = {sda_pipe_q[1:0], sda_i};
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        idx_hi_d   = idx_hi_q;
        ptr_d      = ptr_q;
        rack_d     = rack_q;
        sda_oe_d   = sda_oe_q;
        wr_en      = 1'b0;

        if (start_ev) begin
            state_d   = ADDR;
            bit_cnt_d = 4'd0;
            sda_oe_d  = 1'b0;
        end else if (stop_ev) begin
            state_d  = IDLE;
            sda_oe_d = 1'b0;
        end else if (scl_rise) begin
            case (state_q)
                ADDR, IDX_HI, IDX_LO, WDATA: begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end
                RDATA:   bit_cnt_d = bit_cnt_q + 4'd1;
                RACK:    rack_d = ~sda_s;
                default: ;
            endcase
        end else if (scl_fall) begin
            case (state_q)
                ADDR: if (bit_cnt_q == 4'd8) begin
                    if (shift_q[7:1] == DEV_ADDR) begin
                        state_d  = ACK_ADDR;
                        sda_oe_d = 1'b1;
                    end else begin
                        state_d = IGNORE;
                    end
                end
                ACK_ADDR, RACK: begin
                    // shift_q[0] still holds R/W here; rack_q is the master's ACK
                    if ((state_q == ACK_ADDR && shift_q[0]) || (state_q == RACK && rack_q)) begin
                        state_d   = RDATA;
                        shift_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        ptr_d     = ptr_q + 12'd1;
                        bit_cnt_d = 4'd0;
                    end else if (state_q == ACK_ADDR) begin
                        state_d   = IDX_HI;
                        sda_oe_d  = 1'b0;
                        bit_cnt_d = 4'd0;
                    end else begin
                        state_d  = IGNORE;
                        sda_oe_d = 1'b0;
                    end
                end
                IDX_HI: if (bit_cnt_q == 4'd8) begin
                    idx_hi_d = shift_q[3:0];
                    sda_oe_d = 1'b1;
                    state_d  = ACK_HI;
                end
                IDX_LO: if (bit_cnt_q == 4'd8) begin
                    ptr_d    = {idx_hi_q, shift_q};
                    sda_oe_d = 1'b1;
                    state_d  = ACK_LO;
                end
                WDATA: if (bit_cnt_q == 4'd8) begin
                    wr_en    = 1'b1;
                    ptr_d    = ptr_q + 12'd1;
                    sda_oe_d = 1'b1;
                    state_d  = ACK_W;
                end
                ACK_HI, ACK_LO, ACK_W: begin
                    sda_oe_d  = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = (state_q == ACK_HI) ? IDX_LO : WDATA;
                end
                RDATA: begin
                    if (bit_cnt_q == 4'd8) begin
                        sda_oe_d = 1'b0;
                        state_d  = RACK;
                    end else begin
                        shift_d  = {shift_q[6:0], 1'b0};
                        sda_oe_d = ~shift_q[6];
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        fresh_d     = fresh_q;
        int_st_d    = int_st_q;
        range_val_d = range_val_q;
        busy_d      = busy_q;
        meas_cnt_d  = meas_cnt_q;

        if (wr_en && ptr_q == 12'h016) fresh_d = shift_q[0];
        if (wr_en && ptr_q == 12'h015 && shift_q[0]) int_st_d = 3'd0;
        if (wr_en && ptr_q == 12'h018 && shift_q[0] && !busy_q) begin
            busy_d     = 1'b1;
            meas_cnt_d = MEAS_CYCLES - 24'd1;
        end
        // completion is applied last so it beats a clear landing in the same clk
        if (busy_q) begin
            if (meas_cnt_q == 24'd0) begin
                busy_d      = 1'b0;
                range_val_d = range_mm;
                int_st_d    = 3'b100;
            end else begin
                meas_cnt_d = meas_cnt_q - 24'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_pipe_q  <= 3'b111;
            sda_pipe_q  <= 3'b111;
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            idx_hi_q    <= 4'd0;
            ptr_q       <= 12'd0;
            rack_q      <= 1'b0;
            sda_oe_q    <= 1'b0;
            fresh_q     <= 1'b1;
            int_st_q    <= 3'd0;
            range_val_q <= 8'd0;
            busy_q      <= 1'b0;
            meas_cnt_q  <= 24'd0;
        end else begin
            scl_pipe_q  <= scl_pipe_d;
            sda_pipe_q  <= sda_pipe_d;
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            idx_hi_q    <= idx_hi_d;
            ptr_q       <= ptr_d;
            rack_q      <= rack_d;
            sda_oe_q    <= sda_oe_d;
            fresh_q     <= fresh_d;
            int_st_q    <= int_st_d;
            range_val_q <= range_val_d;
            busy_q      <= busy_d;
            meas_cnt_q  <= meas_cnt_d;
        end
    end

`ifdef VL6180X_GPIO1_INT_EN
    logic gpio_q, gpio_d;
    assign gpio_d = ~(int_st_q != 3'd0);
    always_ff @(posedge clk) begin
        if (!rst_n) gpio_q <= 1'b1;
        else        gpio_q <= gpio_d;
    end
    assign gpio1_n = gpio_q;
`else
    assign gpio1_n = 1'b1;
`endif

endmodule
